alu_issue_queue: RTL and testbench

Operation-issue stage that sits directly upstream of the 4-bit combinational ALU (`alu_final`). It accepts {select, A, B} operation requests over a valid/ready handshake, buffers them in a small FIFO, and drives the ALU's `S`/`A`/`B` inputs from a registered issue slot. One cycle later it captures the ALU's `FINAL_OUTPUT`/`FINAL_CARRY_BORROW` into a result register and presents it downstream over a second valid/ready handshake, with full backpressure.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_issue_queue_if.sv | 31 +++
 rtl/alu_final.sv | 40 ++++
 rtl/alu_req_fifo.sv | 58 +++++
 rtl/alu_issue_queue.sv | 99 +++++++++
 tb/tb_alu_issue_queue.sv | 261 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU issue stage and the ALU it feeds.
//   - ALU_W        : native operand width of the ALU
//   - alu_sel_t    : 2-bit operation select
//   - ALU_AND/ADD/SUB/CMP : select encodings
//   - alu_req_t    : one operation request {sel, a, b} at the native width
package alu_pkg;

    localparam int ALU_W = 4;

    typedef logic [1:0] alu_sel_t;

    localparam alu_sel_t ALU_AND = 2'b00;
    localparam alu_sel_t ALU_ADD = 2'b01;
    localparam alu_sel_t ALU_SUB = 2'b10;
    localparam alu_sel_t ALU_CMP = 2'b11;

    typedef struct packed {
        alu_sel_t           sel;
        logic [ALU_W-1:0]   a;
        logic [ALU_W-1:0]   b;
    } alu_req_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// alu_issue_queue_if
//   Request and result handshakes of the ALU issue stage.
//   Request side : in_valid, in_ready, in_sel, in_a, in_b
//   Result side  : out_valid, out_ready, out_result, out_cb, out_sel
//   modport master : the producer/consumer around the issue stage
//   modport slave  : the issue stage itself
interface alu_issue_queue_if #(
    parameter int WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    alu_pkg::alu_sel_t      in_sel;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;

    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_result;
    logic                   out_cb;
    alu_pkg::alu_sel_t      out_sel;

    modport master (
        output in_valid, in_sel, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_cb, out_sel
    );

    modport slave (
        input  in_valid, in_sel, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_cb, out_sel
    );
endinterface

// File: rtl/alu_final.sv
// alu_final
//   Combinational ALU driven by the issue stage.
//   S                  : operation select (AND, ADD, SUB, COMPARE)
//   A, B               : operands
//   FINAL_OUTPUT       : AND -> A&B; ADD -> A+B; SUB -> A-B;
//                        COMPARE -> {.., A<B, A>B, A==B} in bits [2:0]
//   FINAL_CARRY_BORROW : ADD carry-out; SUB/COMPARE borrow (A<B); AND 0
module alu_final import alu_pkg::*; #(
    parameter int WIDTH = 4
) (
    input  alu_sel_t            S,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    output logic [WIDTH-1:0]    FINAL_OUTPUT,
    output logic                FINAL_CARRY_BORROW
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, A} + {1'b0, B};
    // Top bit of the widened subtraction is the borrow (set when A < B).
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        FINAL_OUTPUT       = '0;
        FINAL_CARRY_BORROW = 1'b0;
        case (S)
            ALU_AND: FINAL_OUTPUT = A & B;
            ALU_ADD: {FINAL_CARRY_BORROW, FINAL_OUTPUT} = sum;
            ALU_SUB: {FINAL_CARRY_BORROW, FINAL_OUTPUT} = diff;
            ALU_CMP: begin
                FINAL_OUTPUT[0]    = (A == B);
                FINAL_OUTPUT[1]    = (A > B);
                FINAL_OUTPUT[2]    = (A < B);
                FINAL_CARRY_BORROW = (A < B);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_req_fifo.sv
// alu_req_fifo
//   Synchronous FIFO with asynchronous active-high reset.
//   clk, rst : clock, async reset (pointers and count only; storage is not reset)
//   push     : write wdata; ignored while full
//   pop      : advance the head; ignored while empty
//   rdata    : current head entry (valid while !empty)
//   full, empty, count : occupancy, derived from count
module alu_req_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        pop,
    output logic [DATA_W-1:0]           rdata,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A push is refused at full even if a pop frees a slot in the same cycle,
    // so the ready seen upstream depends on registered state only.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Issue stage in front of a combinational ALU: FIFO -> issue register
//   (drives S/A/B) -> result register (captures the ALU output one cycle later).
//   clk, rst      : clock, async active-high reset
//   bus (slave)   : request handshake in, result handshake out
//   S, A, B       : registered ALU select/operands
//   alu_out/alu_cb: ALU result and carry/borrow fed back
//   count         : FIFO occupancy
module alu_issue_queue import alu_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    alu_issue_queue_if.slave            bus,
    output alu_sel_t                    S,
    output logic [WIDTH-1:0]            A,
    output logic [WIDTH-1:0]            B,
    input  logic [WIDTH-1:0]            alu_out,
    input  logic                        alu_cb,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int REQ_W = 2 + 2*WIDTH;

    logic               fifo_full;
    logic               fifo_empty;
    logic [REQ_W-1:0]   head;
    logic               pop;
    logic               iss_v;
    logic               res_adv;
    logic               iss_adv;

    logic               res_v;
    logic [WIDTH-1:0]   res_data;
    logic               res_cb;
    alu_sel_t           res_sel;

    assign bus.in_ready   = !fifo_full;
    assign bus.out_valid  = res_v;
    assign bus.out_result = res_data;
    assign bus.out_cb     = res_cb;
    assign bus.out_sel    = res_sel;

    // Backpressure ripples back one stage at a time; an empty slot always advances.
    assign res_adv = !res_v || bus.out_ready;
    assign iss_adv = !iss_v || res_adv;
    assign pop     = iss_adv && !fifo_empty;

    alu_req_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .wdata ({bus.in_sel, bus.in_a, bus.in_b}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    // Issue stage: S/A/B hold their last values when nothing is issued,
    // keeping the ALU inputs quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_v <= 1'b0;
            S     <= '0;
            A     <= '0;
            B     <= '0;
        end else if (iss_adv) begin
            if (!fifo_empty) begin
                iss_v     <= 1'b1;
                {S, A, B} <= head;
            end else begin
                iss_v <= 1'b0;
            end
        end
    end

    // Result stage: ALU output sampled only for a valid issue; data fields
    // otherwise keep the previous result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_v    <= 1'b0;
            res_data <= '0;
            res_cb   <= 1'b0;
            res_sel  <= '0;
        end else if (res_adv) begin
            res_v <= iss_v;
            if (iss_v) begin
                res_data <= alu_out;
                res_cb   <= alu_cb;
                res_sel  <= S;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_queue_if #(.WIDTH(WIDTH)) bus();

    alu_sel_t           S;
    logic [WIDTH-1:0]   A, B, alu_out;
    logic               alu_cb;
    logic [CNT_W-1:0]   count;

    alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .S(S), .A(A), .B(B),
        .alu_out(alu_out), .alu_cb(alu_cb), .count(count)
    );

    alu_final #(.WIDTH(WIDTH)) alu (
        .S(S), .A(A), .B(B),
        .FINAL_OUTPUT(alu_out), .FINAL_CARRY_BORROW(alu_cb)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int del_cnt  = 0;

    alu_req_t sb[$];
    int       hs_cyc[$];
    int       hs_res[$];

    logic        stall;
    logic [6:0]  saved;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference ALU: {carry/borrow, result} from plain integer arithmetic.
    function automatic logic [4:0] alu_ref(input alu_req_t r);
        int a, b, s;
        logic [3:0] res;
        logic c;
        a = int'(r.a);
        b = int'(r.b);
        case (r.sel)
            2'b00: begin res = 4'(a & b); c = 1'b0; end
            2'b01: begin s = a + b; res = 4'(s % 16); c = (s > 15); end
            2'b10: begin s = a - b; res = 4'((s + 16) % 16); c = (a < b); end
            default: begin
                res = (a == b) ? 4'd1 : ((a > b) ? 4'd2 : 4'd4);
                c = (a < b);
            end
        endcase
        return {c, res};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        alu_req_t   e;
        logic [4:0] r;
        cyc++;
        if (rst) begin
            sb.delete();
            stall = 1'b0;
        end else begin
            check("in_ready_vs_count", 32'(bus.in_ready), 32'(count != CNT_W'(DEPTH)));
            if (stall) begin
                check("stalled_valid", 32'(bus.out_valid), 32'd1);
                check("stalled_fields", 32'({bus.out_sel, bus.out_cb, bus.out_result}), 32'(saved));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    r = alu_ref(e);
                    check("sb_result", 32'(bus.out_result), 32'(r[3:0]));
                    check("sb_cb", 32'(bus.out_cb), 32'(r[4]));
                    check("sb_sel", 32'(bus.out_sel), 32'(e.sel));
                end
                del_cnt++;
                hs_cyc.push_back(cyc);
                hs_res.push_back(int'(bus.out_result));
            end
            stall = bus.out_valid && !bus.out_ready;
            saved = {bus.out_sel, bus.out_cb, bus.out_result};
            if (bus.in_valid && bus.in_ready) begin
                e.sel = bus.in_sel; e.a = bus.in_a; e.b = bus.in_b;
                sb.push_back(e);
                acc_cnt++;
            end
        end
    end

    task automatic push_op(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
        bus.in_valid = 1'b1;
        bus.in_sel = s; bus.in_a = a; bus.in_b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_S"}, 32'(S), 32'd0);
        check({tag, "_A"}, 32'(A), 32'd0);
        check({tag, "_B"}, 32'(B), 32'd0);
        check({tag, "_out_result"}, 32'(bus.out_result), 32'd0);
        check({tag, "_out_cb"}, 32'(bus.out_cb), 32'd0);
        check({tag, "_out_sel"}, 32'(bus.out_sel), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] bs [4];
        logic [3:0] ba [4];
        logic [3:0] bb [4];
        int base_hs, base_acc, base_del, n;
        alu_req_t pr;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_a = '0; bus.in_b = '0;
        bus.out_ready = 1'b1;
        #1;
        check_reset_vals("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Pin the reference model with hand-computed values.
        pr = '{sel: 2'b01, a: 4'd3, b: 4'd3};  check("ref_add", 32'(alu_ref(pr)), 32'h06);
        pr = '{sel: 2'b10, a: 4'd3, b: 4'd5};  check("ref_sub", 32'(alu_ref(pr)), 32'h1E);
        pr = '{sel: 2'b01, a: 4'd9, b: 4'd8};  check("ref_carry", 32'(alu_ref(pr)), 32'h11);
        pr = '{sel: 2'b11, a: 4'd6, b: 4'd2};  check("ref_cmp", 32'(alu_ref(pr)), 32'h02);

        // Single operation latency.
        push_op(2'b01, 4'b0011, 4'b0011);
        check("single_count", 32'(count), 32'd1);
        @(posedge clk); #1;
        check("single_S", 32'(S), 32'd1);
        check("single_A", 32'(A), 32'd3);
        check("single_B", 32'(B), 32'd3);
        check("single_not_yet", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_result", 32'(bus.out_result), 32'd6);
        check("single_cb", 32'(bus.out_cb), 32'd0);
        check("single_sel", 32'(bus.out_sel), 32'd1);
        repeat (2) @(posedge clk); #1;

        // Back-to-back, no gaps.
        bs = '{2'b01, 2'b01, 2'b11, 2'b10};
        ba = '{4'b0001, 4'b0110, 4'b0011, 4'b0011};
        bb = '{4'b0011, 4'b0010, 4'b0011, 4'b0011};
        base_hs = hs_cyc.size();
        for (int i = 0; i < 4; i++) push_op(bs[i], ba[i], bb[i]);
        repeat (6) @(posedge clk); #1;
        check("b2b_count", 32'(hs_cyc.size() - base_hs), 32'd4);
        if (hs_cyc.size() - base_hs == 4) begin
            for (int k = 1; k < 4; k++)
                check("b2b_gap", 32'(hs_cyc[base_hs+k] - hs_cyc[base_hs+k-1]), 32'd1);
            check("b2b_res0", 32'(hs_res[base_hs+0]), 32'd4);
            check("b2b_res1", 32'(hs_res[base_hs+1]), 32'd8);
            check("b2b_res2", 32'(hs_res[base_hs+2]), 32'd1);
            check("b2b_res3", 32'(hs_res[base_hs+3]), 32'd0);
        end

        // Backpressure: fill result, issue and all FIFO slots.
        bus.out_ready = 1'b0;
        base_acc = acc_cnt;
        base_del = del_cnt;
        for (int i = 0; i < 6; i++)
            push_op(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
        check("bp_accepted", 32'(acc_cnt - base_acc), 32'd6);
        check("bp_count_full", 32'(count), 32'(DEPTH));
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);

        // Full with a simultaneous pop: the request must be refused.
        bus.in_valid = 1'b1; bus.in_sel = 2'b01; bus.in_a = 4'd7; bus.in_b = 4'd7;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("full_pop_count", 32'(count), 32'd3);
        check("full_pop_in_ready", 32'(bus.in_ready), 32'd1);
        check("full_pop_refused", 32'(acc_cnt - base_acc), 32'd6);
        repeat (10) @(posedge clk); #1;
        check("bp_delivered", 32'(del_cnt - base_del), 32'd6);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Wrap-around with random traffic and backpressure.
        base_acc = acc_cnt;
        base_del = del_cnt;
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (acc_cnt - base_acc < 3*DEPTH+1) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_sel = 2'($urandom_range(0, 3));
                bus.in_a = 4'($urandom);
                bus.in_b = 4'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            n = c;
            if (acc_cnt - base_acc == 3*DEPTH+1 && sb.size() == 0 && !bus.out_valid) break;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("wrap_in_time", 32'(n < 2999), 32'd1);
        check("wrap_accepted", 32'(acc_cnt - base_acc), 32'(3*DEPTH+1));
        check("wrap_delivered", 32'(del_cnt - base_del), 32'(3*DEPTH+1));

        // Reset mid-operation with three entries queued.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_op(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
        check("pre_reset_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        base_del = del_cnt;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_reset_no_valid", 32'(bus.out_valid), 32'd0);
            check("post_reset_count", 32'(count), 32'd0);
        end
        check("post_reset_no_delivery", 32'(del_cnt - base_del), 32'd0);
        push_op(2'b00, 4'b1100, 4'b1010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("post_reset_valid", 32'(bus.out_valid), 32'd1);
        check("post_reset_result", 32'(bus.out_result), 32'd8);
        check("post_reset_sel", 32'(bus.out_sel), 32'd0);
        repeat (3) @(posedge clk); #1;
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
